ej32_mem_dump: RTL and testbench
================================

# ej32_mem_dump

Streaming memory reader and the counterpart of the eForth image loader. Where the loader copies the ROM image into SPRAM byte by byte, this block reads a byte range back out of SPRAM over the 8-bit memory bus. It presents the bytes on a valid/ready byte stream and keeps a running 32-bit checksum. It sits beside the core on the memory bus and is used for image verification, debug dumps and the output-buffer drain.

## Interface
- ASZ, 17, byte address width (128 KB)
- DSZ, 32, checksum width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- base  in  ASZ  first byte address, latched on accepted start
- len  in  ASZ  byte count, latched on accepted start; 0 is legal
- abort  in  1  cancel the dump in progress
- busy  out  1  high from accepted start until done or abort
- done  out  1  one-cycle pulse after the last byte is accepted downstream
- sum  out  DSZ  running sum of all bytes accepted downstream since the last start
- mem_a  out  ASZ  memory read address
- mem_re  out  1  read strobe, one cycle per byte
- mem_vo  in  8  read data, valid the cycle after mem_re
- o_vld  out  1  output byte valid
- o_dat  out  8  output byte
- o_rdy  in  1  downstream accepts the byte when o_vld & o_rdy

## Operation
- Reset values (rst low): busy 0, done 0, sum 0, mem_a 0, mem_re 0, o_vld 0, o_dat 0. The FIFO is empty, no read is pending, the FSM is in IDLE.
- States:
  - IDLE: start=1 with len≠0 latches base/len, clears sum and goes to RUN. start=1 with len=0 clears sum, stays in IDLE and pulses done next cycle; no memory access.
  - RUN: reads are issued, captured and streamed.
  - FIN: one cycle; done=1, busy=0; then IDLE.
- Counters:
  - iss_cnt: bytes left to issue.
  - pop_cnt: bytes left to deliver.
  - pend: a read is in flight.
  - fill: FIFO occupancy, 0..2.
- Issue rule, evaluated in RUN:
  - Issue when iss_cnt≠0 and fill + pend − pop < 2, where pop = o_vld & o_rdy.
  - On issue: mem_re=1, mem_a=current address, address += 1, iss_cnt −= 1.
- Address wraps modulo 2^ASZ: 'h1FFFF → 'h0 at ASZ=17.
- Capture: the cycle after mem_re, mem_vo is written into the 2-entry FIFO and pend clears. The FIFO never overflows under the issue rule; overflow is an assertion failure.
- Output: o_vld = (fill≠0), o_dat = FIFO head.
- On pop:
  - sum += {24'b0, o_dat}, wrapping at 2^DSZ.
  - pop_cnt −= 1.
  - pop_cnt reaching 0 moves RUN → FIN.
- mem_re is 0 whenever no read issues; mem_a holds its last value.
- abort in RUN:
  - Next cycle returns to IDLE with busy=0, fill=0, o_vld=0.
  - An in-flight read is discarded.
  - No done pulse; sum holds its partial value.
  - abort in IDLE or FIN is ignored.
- start is ignored while busy=1 or in FIN.
- Simultaneous pop and capture in one cycle: fill is unchanged and head/tail advance correctly.
- The block never writes memory.

## Timing
- Reference point: start sampled at the cycle-0 edge.
  - Cycle 1: busy=1, first mem_re with mem_a=base.
  - Cycle 2: byte on mem_vo.
  - Cycle 3: o_vld=1.
- Throughput with o_rdy held high: one byte per cycle. For len=N, bytes appear on cycles 3..N+2 and done=1 on cycle N+3, with busy=0 on that same cycle.
- o_rdy low: at most 2 bytes are buffered and issue stalls. o_vld/o_dat stay stable until accepted.
- o_vld never depends combinationally on o_rdy. mem_re does depend on o_rdy through the pop term.
- The len=0 done pulse comes 1 cycle after start.
- rst low mid-RUN returns all outputs to their reset values immediately (asynchronously); after release the block is in IDLE.

## Test plan
- Bytes 01,02,03,04 at 'h10, base='h10, len=4, o_rdy=1:
  - o_dat = 01..04 on cycles 3–6.
  - done on cycle 7.
  - sum='h0A.
  - mem_a = 'h10..'h13.
- Same setup, o_rdy low on cycles 3–6:
  - At most 2 mem_re issued before the stall.
  - o_dat holds 01 while stalled.
  - All 4 bytes then arrive in order; sum='h0A; exactly 4 mem_re total.
- len=0 → done on cycle 1; mem_re never asserted; sum=0.
- Wrap and overflow:
  - base='h1FFFF, len=3 with bytes FF,80,01 → mem_a 'h1FFFF, 'h0, 'h1; sum='h180.
  - With sum preloaded by a prior run, start clears it.
- abort on cycle 4 of a len=8 run:
  - busy=0 on cycle 5; no done; o_vld=0.
  - sum = total of bytes popped before the abort.
  - A subsequent start runs normally.
- rst low during RUN:
  - All outputs return to their reset values while rst is low.
  - A start after release reproduces the first scenario exactly.

Source files
------------

// File: rtl/ej32_mem_dump.sv
// Streaming SPRAM reader: fetches a byte range over the 8-bit memory bus,
// presents it on a valid/ready byte stream and keeps a running checksum.
module ej32_mem_dump #(
  parameter int ASZ = 17,
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [ASZ-1:0] base,
  input  logic [ASZ-1:0] len,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic [DSZ-1:0] sum,
  output logic [ASZ-1:0] mem_a,
  output logic           mem_re,
  input  logic [7:0]     mem_vo,
  output logic           o_vld,
  output logic [7:0]     o_dat,
  input  logic           o_rdy
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state, state_nxt;
  logic [ASZ-1:0] addr;
  logic [ASZ-1:0] a_last;
  logic [ASZ-1:0] iss_cnt;
  logic [ASZ-1:0] pop_cnt;
  logic           pend;
  logic [1:0]     fill;
  logic           wptr, rptr;
  logic [7:0]     fifo [2];
  logic           done_q;

  logic go, go_zero, issue, pop, cap, last_pop, kill;

  function automatic logic [DSZ-1:0] sum_add(input logic [DSZ-1:0] acc,
                                             input logic [7:0]     b);
    return acc + DSZ'(b);
  endfunction

  assign pop      = o_vld & o_rdy;
  assign cap      = pend;
  assign go       = (state == IDLE) && start && (len != '0);
  assign go_zero  = (state == IDLE) && start && (len == '0);
  assign kill     = (state == RUN) && abort;
  assign last_pop = pop && (pop_cnt == ASZ'(1));
  // Counting the pop keeps streaming at one byte per cycle with a 2-deep FIFO.
  assign issue    = (state == RUN) && !abort && (iss_cnt != '0) &&
                    (({1'b0, fill} + {2'b0, pend}) < (3'd2 + {2'b0, pop}));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (last_pop) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state == RUN);
  assign done   = done_q;
  assign mem_re = issue;
  assign mem_a  = issue ? addr : a_last;
  assign o_vld  = (fill != 2'd0);
  assign o_dat  = o_vld ? fifo[rptr] : 8'h00;

  // Issue stage: address/count bookkeeping and FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr    <= '0;
      a_last  <= '0;
      iss_cnt <= '0;
      pop_cnt <= '0;
      done_q  <= 1'b0;
      sum     <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= go_zero || ((state == RUN) && !abort && last_pop);
      if (go) begin
        addr    <= base;
        iss_cnt <= len;
        pop_cnt <= len;
      end
      if (issue) begin
        a_last  <= addr;
        addr    <= addr + ASZ'(1);
        iss_cnt <= iss_cnt - ASZ'(1);
      end
      if (pop) pop_cnt <= pop_cnt - ASZ'(1);
      if (go || go_zero) sum <= '0;
      else if (pop)      sum <= sum_add(sum, o_dat);
    end
  end

  // Capture stage: read response into the 2-entry FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;
      fill <= 2'd0;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else if (kill) begin
      pend <= 1'b0;
      fill <= 2'd0;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      pend <= issue;
      wptr <= wptr ^ cap;
      rptr <= rptr ^ pop;
      case ({cap, pop})
        2'b10:   fill <= fill + 2'd1;
        2'b01:   fill <= fill - 2'd1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cap) fifo[wptr] <= mem_vo;
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!(cap && !pop && (fill == 2'd2)));
  end

endmodule

// File: tb/tb_ej32_mem_dump.sv
// Bench for ej32_mem_dump: directed scenarios plus randomized dumps checked
// against a byte-range/checksum model of the SPRAM contents.
module tb_ej32_mem_dump;

  localparam int ASZ = 17;
  localparam int DSZ = 32;
  localparam int MSZ = 131072;

  logic           clk, rst, start, abort, o_rdy;
  logic [ASZ-1:0] base, len;
  logic           busy, done, mem_re, o_vld;
  logic [DSZ-1:0] sum;
  logic [ASZ-1:0] mem_a;
  logic [7:0]     mem_vo, o_dat;

  ej32_mem_dump #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .abort(abort), .busy(busy), .done(done), .sum(sum), .mem_a(mem_a),
    .mem_re(mem_re), .mem_vo(mem_vo), .o_vld(o_vld), .o_dat(o_dat),
    .o_rdy(o_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:MSZ-1];
  initial mem_vo = 8'h00;
  always @(posedge clk) if (mem_re) mem_vo <= mem[mem_a];

  int cyc = 0;
  int e0  = 32'h3fffffff;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ASZ-1:0] a_log    [256];
  logic [7:0]     dat_log  [256];
  logic [DSZ-1:0] sum_log  [256];
  logic           re_log   [256];
  logic           vld_log  [256];
  logic           pop_log  [256];
  logic           done_log [256];
  logic           busy_log [256];

  always @(negedge clk) begin
    int r;
    r = cyc - e0 + 1;
    if (r >= 1 && r < 256) begin
      re_log[r]   = mem_re;
      a_log[r]    = mem_a;
      vld_log[r]  = o_vld;
      dat_log[r]  = o_dat;
      pop_log[r]  = o_vld & o_rdy;
      done_log[r] = done;
      busy_log[r] = busy;
      sum_log[r]  = sum;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    e0 = 32'h3fffffff;
    for (int i = 0; i < 256; i++) begin
      re_log[i] = 0; a_log[i] = 0; vld_log[i] = 0; dat_log[i] = 0;
      pop_log[i] = 0; done_log[i] = 0; busy_log[i] = 0; sum_log[i] = 0;
    end
  endtask

  // mode 0: o_rdy always high; 1: o_rdy low on cycles 3..6; 2: random o_rdy
  task automatic run(input logic [ASZ-1:0] b, input logic [ASZ-1:0] n,
                     input int mode, input int abort_at, input int ncyc);
    clear_logs();
    base  = b;
    len   = n;
    start = 1'b1;
    @(posedge clk); #1;
    e0    = cyc;
    start = 1'b0;
    for (int r = 1; r <= ncyc; r++) begin
      if (mode == 1)      o_rdy = !(r >= 3 && r <= 6);
      else if (mode == 2) o_rdy = ($urandom_range(3, 0) != 0);
      else                o_rdy = 1'b1;
      abort = (r == abort_at);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    o_rdy = 1'b1;
  endtask

  // Model: the dump reads (b+i) mod 2^ASZ for i<n, delivers those bytes in
  // order, sums them mod 2^DSZ and pulses done once, one cycle after the last
  // byte (or on cycle 1 for an empty range).
  task automatic verify(input string tag, input logic [ASZ-1:0] b, input int n,
                        input bit exact);
    int nre, npop, ndone, dcyc, lastpop, outst, maxout, stab_bad, idx;
    int unsigned msum;
    nre = 0; npop = 0; ndone = 0; dcyc = 0; lastpop = 0;
    maxout = 0; stab_bad = 0; msum = 0;
    for (int r = 1; r < 256; r++) begin
      if (re_log[r]) begin
        idx = (int'(b) + nre) % MSZ;
        chk({tag, "_addr"}, a_log[r], idx);
        if (exact) chk({tag, "_re_cycle"}, r, nre + 1);
        nre++;
      end
      if (pop_log[r]) begin
        idx = (int'(b) + npop) % MSZ;
        chk({tag, "_byte"}, dat_log[r], mem[idx]);
        if (exact) chk({tag, "_byte_cycle"}, r, npop + 3);
        msum += mem[idx];
        npop++;
        lastpop = r;
      end
      outst = nre - npop;
      if (outst > maxout) maxout = outst;
      if (done_log[r]) begin ndone++; dcyc = r; end
      if (r < 255 && vld_log[r] && !pop_log[r] && busy_log[r])
        if (!vld_log[r+1] || dat_log[r+1] !== dat_log[r]) stab_bad++;
    end
    chk({tag, "_re_count"}, nre, n);
    chk({tag, "_byte_count"}, npop, n);
    chk({tag, "_done_count"}, ndone, 1);
    chk({tag, "_done_cycle"}, dcyc, (n == 0) ? 1 : lastpop + 1);
    if (exact) chk({tag, "_done_cycle_abs"}, dcyc, (n == 0) ? 1 : n + 3);
    chk({tag, "_busy_at_done"}, busy_log[dcyc], 0);
    chk({tag, "_sum"}, sum, msum);
    chk({tag, "_max_outstanding_le2"}, (maxout <= 2), 1);
    chk({tag, "_hold_while_stalled"}, stab_bad, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},   busy,   0);
    chk({tag, "_done"},   done,   0);
    chk({tag, "_sum"},    sum,    0);
    chk({tag, "_mem_a"},  mem_a,  0);
    chk({tag, "_mem_re"}, mem_re, 0);
    chk({tag, "_o_vld"},  o_vld,  0);
    chk({tag, "_o_dat"},  o_dat,  0);
  endtask

  initial begin
    int ndone, nre_early;
    logic [ASZ-1:0] rb;
    int rn;
    rst = 1'b0; start = 1'b0; abort = 1'b0; o_rdy = 1'b1;
    base = '0; len = '0;
    for (int i = 0; i < MSZ; i++) mem[i] = 8'($urandom);
    mem[16] = 8'h01; mem[17] = 8'h02; mem[18] = 8'h03; mem[19] = 8'h04;
    mem[MSZ-1] = 8'hFF; mem[0] = 8'h80; mem[1] = 8'h01;
    clear_logs();

    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic four-byte dump at full throughput
    run(17'h10, 17'd4, 0, 0, 10);
    verify("basic", 17'h10, 4, 1);
    chk("basic_sum_0A", sum, 32'h0A);

    // Downstream stall on cycles 3..6
    run(17'h10, 17'd4, 1, 0, 20);
    nre_early = 0;
    for (int r = 1; r <= 6; r++) if (re_log[r]) nre_early++;
    chk("stall_reads_before_stall", nre_early, 2);
    for (int r = 3; r <= 6; r++) chk("stall_hold_01", {vld_log[r], dat_log[r]}, {1'b1, 8'h01});
    verify("stall", 17'h10, 4, 0);
    chk("stall_sum_0A", sum, 32'h0A);

    // Address wrap; previous sum is cleared by the start
    run(17'h1FFFF, 17'd3, 0, 0, 9);
    chk("wrap_sum_cleared", sum_log[1], 0);
    verify("wrap", 17'h1FFFF, 3, 1);
    chk("wrap_sum_180", sum, 32'h180);

    // Empty range
    run(17'h10, 17'd0, 0, 0, 6);
    verify("len0", 17'h10, 0, 1);
    chk("len0_sum", sum, 0);

    // Abort on cycle 4 of an 8-byte dump
    run(17'h40, 17'd8, 0, 4, 14);
    ndone = 0;
    for (int r = 1; r < 256; r++) if (done_log[r]) ndone++;
    chk("abort_busy_c4", busy_log[4], 1);
    chk("abort_busy_c5", busy_log[5], 0);
    chk("abort_vld_c5", vld_log[5], 0);
    chk("abort_no_done", ndone, 0);
    chk("abort_partial_sum", sum, 32'(mem[17'h40]) + 32'(mem[17'h41]));
    run(17'h10, 17'd4, 0, 0, 10);
    verify("after_abort", 17'h10, 4, 1);

    // Asynchronous reset in the middle of a dump
    clear_logs();
    base = 17'h10; len = 17'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midrun_rst");
    @(posedge clk); #1;
    chk_reset_outputs("midrun_rst_held");
    rst = 1'b1;
    @(posedge clk); #1;
    run(17'h10, 17'd4, 0, 0, 10);
    verify("after_rst", 17'h10, 4, 1);
    chk("after_rst_sum_0A", sum, 32'h0A);

    // Randomized dumps with random backpressure, one forced across the wrap
    for (int k = 0; k < 8; k++) begin
      rb = (k == 0) ? 17'(MSZ - 10) : 17'($urandom_range(MSZ - 1, 0));
      rn = $urandom_range(20, 1);
      for (int i = 0; i < rn; i++) mem[(int'(rb) + i) % MSZ] = 8'($urandom);
      run(rb, 17'(rn), 2, 0, 4 * rn + 12);
      verify("rand", rb, rn, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
